// File: rtl/grain_ctrl_if.sv
// Purpose: session-control and byte-stream bundle between a host and grain_ctrl.
// Latency: none; this is wiring only.
// Backpressure: in_valid/in_ready and out_valid/out_ready pairs carry the stream handshakes.
interface grain_ctrl_if;
    logic        start;
    logic [79:0] seed;
    logic [15:0] msg_len;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    // Host side: starts sessions, supplies bytes, sinks results.
    modport master (
        output start, seed, msg_len, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy, done
    );

    // Controller side.
    modport slave (
        input  start, seed, msg_len, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/grain_ctrl.sv
// Purpose: sequences a Grain keystream core (load, warm-up, 8-bit gather) and XORs bytes with it.
// Latency: 1 + WARMUP_CYCLES + 8 cycles to first in_ready, then 1 cycle in->out, 8 cycles between bytes.
// Backpressure: core shifting stops in WAIT_IN/OUTPUT, so stalls on either side lose no keystream bits.
module grain_ctrl #(
    parameter int unsigned WARMUP_CYCLES = 160
) (
    input  logic        clk,
    input  logic        rst,
    grain_ctrl_if.slave bus,
    output logic        grain_par_load,
    output logic        grain_shift_en,
    output logic [79:0] grain_seed,
    input  logic        grain_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WARMUP  = 3'd2,
        GATHER  = 3'd3,
        WAIT_IN = 3'd4,
        OUTPUT  = 3'd5
    } state_t;

    localparam logic [15:0] WARM_LAST   = 16'(WARMUP_CYCLES - 1);
    localparam logic [15:0] GATHER_LAST = 16'd7;

    state_t      state;
    state_t      state_nxt;

    logic [79:0] seed_q;
    logic [15:0] len_q;
    logic [15:0] byte_cnt;
    logic [15:0] bit_cnt;
    logic [7:0]  ks;
    logic [7:0]  out_data_q;
    logic        done_q;

    logic        start_ok;
    logic        start_empty;
    logic        warm_end;
    logic        gather_end;
    logic        last_byte;

    // Session-start qualifiers and phase-end detectors shared by FSM and datapath.
    always_comb begin
        start_ok    = (state == IDLE) && bus.start && (bus.msg_len != 16'd0);
        start_empty = (state == IDLE) && bus.start && (bus.msg_len == 16'd0);
        warm_end    = (bit_cnt == WARM_LAST);
        gather_end  = (bit_cnt == GATHER_LAST);
        // Compare in 17 bits so a 65535-byte session never sees a wrapped count.
        last_byte   = ({1'b0, byte_cnt} + 17'd1) == {1'b0, len_q};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = WARMUP;
            end
            WARMUP: begin
                if (warm_end) begin
                    state_nxt = GATHER;
                end
            end
            GATHER: begin
                if (gather_end) begin
                    state_nxt = WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (bus.in_valid) begin
                    state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    state_nxt = last_byte ? IDLE : GATHER;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; the core only shifts while warming up or gathering.
    always_comb begin
        bus.busy       = (state != IDLE);
        bus.in_ready   = (state == WAIT_IN);
        bus.out_valid  = (state == OUTPUT);
        bus.out_data   = out_data_q;
        bus.done       = done_q;
        grain_par_load = (state == LOAD);
        grain_shift_en = (state == WARMUP) || (state == GATHER);
        grain_seed     = seed_q;
    end

    // Session datapath: captured parameters, counters, keystream byte, result register, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q     <= '0;
            len_q      <= '0;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            ks         <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        seed_q   <= bus.seed;
                        len_q    <= bus.msg_len;
                        byte_cnt <= '0;
                    end
                    // A zero-length session finishes immediately without touching the core.
                    if (start_empty) begin
                        done_q <= 1'b1;
                    end
                end
                LOAD: begin
                    bit_cnt <= '0;
                end
                WARMUP: begin
                    bit_cnt <= warm_end ? 16'd0 : bit_cnt + 16'd1;
                end
                GATHER: begin
                    // First gathered bit ends up in ks[7].
                    ks      <= {ks[6:0], grain_out};
                    bit_cnt <= gather_end ? 16'd0 : bit_cnt + 16'd1;
                end
                WAIT_IN: begin
                    if (bus.in_valid) begin
                        out_data_q <= bus.in_data ^ ks;
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        byte_cnt <= byte_cnt + 16'd1;
                        if (last_byte) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grain_ctrl.sv
// Purpose: scoreboard bench for grain_ctrl with a stand-in LFSR keystream core.
// Latency: expected bytes are queued when a byte is offered and popped when the DUT presents it.
// Backpressure: out_ready is held low on chosen bytes to exercise output stalls.
module tb_grain_ctrl;

    localparam int W = 160;

    logic        clk = 1'b0;
    logic        rst;
    logic        par_load;
    logic        shift_en;
    logic [79:0] gseed;
    logic        gout;

    grain_ctrl_if bus ();

    grain_ctrl #(.WARMUP_CYCLES(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .grain_par_load (par_load),
        .grain_shift_en (shift_en),
        .grain_seed     (gseed),
        .grain_out      (gout)
    );

    always #5 clk = ~clk;

    // Stand-in keystream core: an 80-bit LFSR with a nonlinear output tap.
    function automatic logic [79:0] lfsr_step(input logic [79:0] s);
        logic fb;
        fb = s[62] ^ s[51] ^ s[38] ^ s[23] ^ s[13] ^ s[0];
        return {fb, s[79:1]};
    endfunction

    function automatic logic lfsr_out(input logic [79:0] s);
        return s[0] ^ s[25] ^ s[46] ^ s[64] ^ (s[3] & s[70]);
    endfunction

    // Reference keystream byte: skip bits, then pack the next 8 with the first bit as MSB.
    function automatic logic [7:0] ks_byte(input logic [79:0] sd, input int skip);
        logic [79:0] s;
        logic [7:0]  v;
        s = sd;
        v = '0;
        for (int i = 0; i < skip; i++) s = lfsr_step(s);
        for (int b = 0; b < 8; b++) begin
            v = {v[6:0], lfsr_out(s)};
            s = lfsr_step(s);
        end
        return v;
    endfunction

    logic [79:0] core_st = '0;
    always @(posedge clk) begin
        if (par_load)      core_st <= gseed;
        else if (shift_en) core_st <= lfsr_step(core_st);
    end
    assign gout = lfsr_out(core_st);

    // Activity counters sampled on the edge that consumes each strobe.
    int shift_cnt = 0;
    int pl_cnt    = 0;
    int done_cnt  = 0;
    always @(posedge clk) begin
        if (shift_en) shift_cnt <= shift_cnt + 1;
        if (par_load) pl_cnt    <= pl_cnt + 1;
        if (bus.done) done_cnt  <= done_cnt + 1;
    end

    int errs   = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic run_session(input logic [79:0] sd, input logic [15:0] len,
                               input logic [7:0] d0, input logic [7:0] dstep,
                               input int stall_byte, input int stall_n, input bit inject,
                               output logic [7:0] last_out);
        int s0, p0, tmo;
        logic [7:0] held, din, exp;
        last_out = '0;
        s0 = shift_cnt;
        p0 = pl_cnt;
        bus.start = 1'b1; bus.seed = sd; bus.msg_len = len;
        @(negedge clk);
        bus.start = 1'b0;
        chk("load_pulse", 80'(par_load), 80'd1);
        chk("load_seed",  gseed, sd);
        chk("load_busy",  80'(bus.busy), 80'd1);
        chk("load_noshift", 80'(shift_en), 80'd0);
        for (int i = 0; i < int'(len); i++) begin
            if (inject && i == 1) begin
                bus.start = 1'b1; bus.seed = ~sd; bus.msg_len = 16'd7;
                @(negedge clk);
                bus.start = 1'b0; bus.seed = sd; bus.msg_len = len;
                chk("seed_kept", gseed, sd);
                chk("still_gather", 80'(shift_en), 80'd1);
            end
            tmo = 0;
            while (!bus.in_ready && tmo < W + 64) begin
                chk("in_ready_gap_valid", 80'(bus.out_valid), 80'd0);
                @(negedge clk);
                tmo++;
            end
            if (!bus.in_ready) begin
                chk("in_ready_wait", 80'(bus.in_ready), 80'd1);
                return;
            end
            chk("wait_noshift", 80'(shift_en), 80'd0);
            din = d0 + dstep * 8'(i);
            exp_q.push_back(din ^ ks_byte(sd, W + 8 * i));
            bus.in_data = din; bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk("in_ready_low", 80'(bus.in_ready), 80'd0);
            chk("out_valid",    80'(bus.out_valid), 80'd1);
            held = bus.out_data;
            if (i == stall_byte) begin
                for (int k = 0; k < stall_n; k++) begin
                    @(negedge clk);
                    chk("stall_valid", 80'(bus.out_valid), 80'd1);
                    chk("stall_data",  80'(bus.out_data), 80'(held));
                    chk("stall_shift", 80'(shift_en), 80'd0);
                end
            end
            exp = exp_q.pop_front();
            chk("out_data", 80'(bus.out_data), 80'(exp));
            last_out = bus.out_data;
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk("out_valid_drop", 80'(bus.out_valid), 80'd0);
        end
        chk("done_pulse", 80'(bus.done), 80'd1);
        chk("end_idle",   80'(bus.busy), 80'd0);
        @(negedge clk);
        chk("done_once",  80'(bus.done), 80'd0);
        chk("shift_total", 80'(shift_cnt - s0), 80'(W + 8 * int'(len)));
        chk("load_total",  80'(pl_cnt - p0), 80'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  80'(bus.busy), 80'd0);
        chk({tag, "_done"},  80'(bus.done), 80'd0);
        chk({tag, "_inrdy"}, 80'(bus.in_ready), 80'd0);
        chk({tag, "_ovld"},  80'(bus.out_valid), 80'd0);
        chk({tag, "_odat"},  80'(bus.out_data), 80'd0);
        chk({tag, "_pload"}, 80'(par_load), 80'd0);
        chk({tag, "_shift"}, 80'(shift_en), 80'd0);
        chk({tag, "_seed"},  gseed, 80'd0);
    endtask

    localparam logic [79:0] SEED_A = 80'h123456789ABCDEF01234;
    localparam logic [79:0] SEED_B = 80'hCAFE0BADF00D5EED4321;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r1, r2, rx;
        int s0, p0, d0;
        rst = 1'b1;
        bus.start = 1'b0; bus.seed = '0; bus.msg_len = '0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst0");
        rst = 1'b0;
        @(negedge clk);

        // Single byte, default warm-up.
        run_session(SEED_A, 16'd1, 8'hA5, 8'h00, -1, 0, 1'b0, r1);

        // Zero-length session completes at once without touching the core.
        s0 = shift_cnt; p0 = pl_cnt;
        bus.start = 1'b1; bus.msg_len = 16'd0; bus.seed = SEED_B;
        @(negedge clk);
        bus.start = 1'b0;
        chk("zero_done",  80'(bus.done), 80'd1);
        chk("zero_busy",  80'(bus.busy), 80'd0);
        chk("zero_pload", 80'(par_load), 80'd0);
        @(negedge clk);
        chk("zero_done_once", 80'(bus.done), 80'd0);
        chk("zero_shift", 80'(shift_cnt - s0), 80'd0);
        chk("zero_loads", 80'(pl_cnt - p0), 80'd0);

        // Three zero bytes expose the raw keystream; byte 2 is stalled for 5 cycles.
        run_session(SEED_B, 16'd3, 8'h00, 8'h00, 1, 5, 1'b0, rx);

        // Reset in the middle of warm-up, with a start request competing.
        d0 = done_cnt;
        bus.start = 1'b1; bus.seed = SEED_A; bus.msg_len = 16'd1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 50; k++) @(negedge clk);
        chk("mid_warmup", 80'(shift_en), 80'd1);
        rst = 1'b1;
        bus.start = 1'b1; bus.seed = SEED_B; bus.msg_len = 16'd5;
        @(negedge clk);
        chk("rst_idle",  80'(bus.busy), 80'd0);
        chk("rst_shift", 80'(shift_en), 80'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        chk_reset_vals("rst1");
        for (int k = 0; k < 20; k++) @(negedge clk);
        chk("rst_no_done", 80'(done_cnt - d0), 80'd0);

        // Rerun of the first session must reproduce its output.
        run_session(SEED_A, 16'd1, 8'hA5, 8'h00, -1, 0, 1'b0, r2);
        chk("rerun_same", 80'(r2), 80'(r1));

        // Start during GATHER with another seed is ignored.
        run_session(SEED_A, 16'd2, 8'h3C, 8'h11, -1, 0, 1'b1, rx);

        // Varied data with a short stall on the last byte.
        run_session(SEED_B, 16'd4, 8'h5A, 8'h37, 3, 2, 1'b0, rx);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
